// File: rtl/usbfifo_ctrl.sv
`default_nettype none
// ============================================================================
// usbfifo_ctrl : FT2232H asynchronous FIFO sequencer with round-robin rd/wr
// Revision     : 1.0
// ============================================================================
module usbfifo_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int RD_PULSE    = 2,
    parameter int WR_SETUP    = 1,
    parameter int WR_PULSE    = 2,
    parameter int RECOVER     = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rxf,
    input  logic       txe,
    output logic       rd,
    output logic       wr,
    input  logic [7:0] rx_data,
    output logic [7:0] tx_data,
    output logic       data_oe,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       busy
);

    localparam int REC_CYCLES = RECOVER + SYNC_STAGES;
    localparam int MAX_A      = (RD_PULSE > WR_SETUP) ? RD_PULSE : WR_SETUP;
    localparam int MAX_B      = (WR_PULSE > REC_CYCLES) ? WR_PULSE : REC_CYCLES;
    localparam int MAX_P      = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W      = $clog2(MAX_P) + 1;

    // Counters load N-1 and the state exits on zero, giving exactly N cycles.
    localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_PULSE - 1);
    localparam logic [CNT_W-1:0] WS_LOAD  = CNT_W'(WR_SETUP - 1);
    localparam logic [CNT_W-1:0] WP_LOAD  = CNT_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(REC_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RD_STROBE = 3'd1;
    localparam logic [2:0] S_WR_SETUP  = 3'd2;
    localparam logic [2:0] S_WR_STROBE = 3'd3;
    localparam logic [2:0] S_WR_HOLD   = 3'd4;
    localparam logic [2:0] S_RECOVER   = 3'd5;

    logic [SYNC_STAGES-1:0] rxf_sync_q;
    logic [SYNC_STAGES-1:0] txe_sync_q;
    logic [2:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rd_q, rd_d;
    logic                   wr_q, wr_d;
    logic                   oe_q, oe_d;
    logic [7:0]             tx_q, tx_d;
    logic [7:0]             out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   prefer_rd_q, prefer_rd_d;

    logic rxf_s, txe_s, idle, read_ok, write_ok, grant_rd, grant_wr;

    assign rxf_s    = rxf_sync_q[SYNC_STAGES-1];
    assign txe_s    = txe_sync_q[SYNC_STAGES-1];
    assign idle     = (state_q == S_IDLE);
    assign read_ok  = idle & ~rxf_s & ~out_valid_q;
    assign write_ok = idle & ~txe_s & in_valid;
    assign grant_rd = read_ok & (~write_ok | prefer_rd_q);
    assign grant_wr = write_ok & (~read_ok | ~prefer_rd_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        oe_d        = oe_q;
        tx_d        = tx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q & ~out_ready;
        prefer_rd_d = prefer_rd_q;
        case (state_q)
            S_IDLE: begin
                if (grant_rd) begin
                    state_d     = S_RD_STROBE;
                    rd_d        = 1'b0;
                    cnt_d       = RD_LOAD;
                    prefer_rd_d = 1'b0;
                end else if (grant_wr) begin
                    state_d     = S_WR_SETUP;
                    tx_d        = in_data;
                    oe_d        = 1'b1;
                    cnt_d       = WS_LOAD;
                    prefer_rd_d = 1'b1;
                end
            end
            S_RD_STROBE: begin
                if (cnt_q == '0) begin
                    rd_d        = 1'b1;
                    out_data_d  = rx_data;
                    out_valid_d = 1'b1;
                    state_d     = S_RECOVER;
                    cnt_d       = REC_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_WR_SETUP: begin
                if (cnt_q == '0) begin
                    wr_d    = 1'b0;
                    state_d = S_WR_STROBE;
                    cnt_d   = WP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_WR_STROBE: begin
                if (cnt_q == '0) begin
                    wr_d    = 1'b1;
                    state_d = S_WR_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_WR_HOLD: begin
                oe_d    = 1'b0;
                state_d = S_RECOVER;
                cnt_d   = REC_LOAD;
            end
            S_RECOVER: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                rd_d    = 1'b1;
                wr_d    = 1'b1;
                oe_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rxf_sync_q  <= '1;
            txe_sync_q  <= '1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rd_q        <= 1'b1;
            wr_q        <= 1'b1;
            oe_q        <= 1'b0;
            tx_q        <= 8'h00;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            prefer_rd_q <= 1'b1;
        end else begin
            rxf_sync_q  <= {rxf_sync_q[SYNC_STAGES-2:0], rxf};
            txe_sync_q  <= {txe_sync_q[SYNC_STAGES-2:0], txe};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            oe_q        <= oe_d;
            tx_q        <= tx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            prefer_rd_q <= prefer_rd_d;
        end
    end

    assign rd        = rd_q;
    assign wr        = wr_q;
    assign data_oe   = oe_q;
    assign tx_data   = tx_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign in_ready  = grant_wr;
    assign busy      = ~idle;

endmodule
`default_nettype wire

// File: tb/tb_usbfifo_ctrl.sv
`default_nettype none
// ============================================================================
// tb_usbfifo_ctrl : directed and randomized bench with a host/stream model
// Revision        : 1.0
// ============================================================================
module tb_usbfifo_ctrl;

    localparam int SYNC_STAGES = 2;
    localparam int RD_PULSE    = 2;
    localparam int WR_SETUP    = 1;
    localparam int WR_PULSE    = 2;
    localparam int RECOVER     = 1;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       rxf = 1'b1;
    logic       txe = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       rd, wr, data_oe, out_valid, in_ready, busy;
    logic [7:0] tx_data, out_data;

    int checks = 0;
    int errors = 0;

    // Host/stream model state: byte queues and strobe tracking
    logic [7:0] host_rx[$];
    logic [7:0] exp_out[$];
    logic [7:0] prod[$];
    logic [7:0] exp_tx[$];
    int         ops[$];
    logic       rd_prev, wr_prev;
    int         rd_run, wr_run;

    usbfifo_ctrl #(
        .SYNC_STAGES(SYNC_STAGES),
        .RD_PULSE   (RD_PULSE),
        .WR_SETUP   (WR_SETUP),
        .WR_PULSE   (WR_PULSE),
        .RECOVER    (RECOVER)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .rxf      (rxf),
        .txe      (txe),
        .rd       (rd),
        .wr       (wr),
        .rx_data  (rx_data),
        .tx_data  (tx_data),
        .data_oe  (data_oe),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    task automatic cycle();
        @(negedge clock);
        checks++;
        if (!rd && !wr) begin
            errors++;
            $display("FAIL strobe_overlap: rd=%b wr=%b, required not both low", rd, wr);
        end
        checks++;
        if (data_oe && !rd) begin
            errors++;
            $display("FAIL oe_during_read: data_oe=%b rd=%b, required data_oe=0 while rd=0", data_oe, rd);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0; rxf = 1'b1; txe = 1'b1; in_valid = 1'b0;
        out_ready = 1'b0; rx_data = 8'h00; in_data = 8'h00;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        rd_prev = 1'b1; wr_prev = 1'b1; rd_run = 0; wr_run = 0;
        host_rx.delete(); exp_out.delete(); prod.delete(); exp_tx.delete(); ops.delete();
    endtask

    // One cycle of the FT2232H host, consumer and producer models.
    task automatic host_step(input int rdy_pct, input int txe_hi_pct);
        cycle();
        if (!rd) begin
            if (rd_prev) ops.push_back(0);
            rd_run++;
        end else if (!rd_prev) begin
            checks++;
            if (host_rx.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: read strobe with no host byte queued");
            end else begin
                if (rd_run != RD_PULSE || out_valid !== 1'b1 || out_data !== host_rx[0]) begin
                    errors++;
                    $display("FAIL rd_capture: width=%0d valid=%b data=%h, required width=%0d valid=1 data=%h",
                             rd_run, out_valid, out_data, RD_PULSE, host_rx[0]);
                end
                exp_out.push_back(host_rx[0]);
                host_rx.delete(0);
            end
            rd_run = 0;
        end
        if (!wr) begin
            if (wr_prev) ops.push_back(1);
            wr_run++;
        end else if (!wr_prev) begin
            checks++;
            if (exp_tx.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: write strobe with no accepted byte");
            end else begin
                if (wr_run != WR_PULSE || data_oe !== 1'b1 || tx_data !== exp_tx[0]) begin
                    errors++;
                    $display("FAIL wr_transfer: width=%0d oe=%b data=%h, required width=%0d oe=1 data=%h",
                             wr_run, data_oe, tx_data, WR_PULSE, exp_tx[0]);
                end
                exp_tx.delete(0);
            end
            wr_run = 0;
        end
        rd_prev = rd;
        wr_prev = wr;

        out_ready = ($urandom_range(99) < rdy_pct);
        if (out_ready && out_valid) begin
            checks++;
            if (exp_out.size() == 0 || out_data !== exp_out[0]) begin
                errors++;
                $display("FAIL out_stream: got %h, required %h (queued=%0d)", out_data,
                         (exp_out.size() != 0) ? exp_out[0] : 8'h00, exp_out.size());
            end
            if (exp_out.size() != 0) exp_out.delete(0);
        end

        rxf     = (host_rx.size() == 0);
        rx_data = (host_rx.size() != 0) ? host_rx[0] : 8'h00;
        txe     = ($urandom_range(99) < txe_hi_pct);

        in_valid = (prod.size() != 0);
        in_data  = in_valid ? prod[0] : 8'h00;
        #1;
        if (in_valid && in_ready) begin
            exp_tx.push_back(prod[0]);
            prod.delete(0);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        @(negedge clock);
        reset_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rxf = 1'($urandom_range(1)); txe = 1'($urandom_range(1));
            in_valid = 1'($urandom_range(1)); out_ready = 1'($urandom_range(1));
            rx_data = 8'($urandom_range(255)); in_data = 8'($urandom_range(255));
            @(negedge clock);
            checks++;
            if ({rd, wr, data_oe, out_valid, in_ready, busy} !== 6'b110000 ||
                out_data !== 8'h00 || tx_data !== 8'h00) begin
                errors++;
                $display("FAIL reset_state: rd,wr,oe,ov,ir,busy=%b out=%h tx=%h, required 110000 00 00",
                         {rd, wr, data_oe, out_valid, in_ready, busy}, out_data, tx_data);
            end
        end
        do_reset();
    endtask

    task automatic test_single_read();
        int t_fall = -1, t_rise = -1, bad = 0;
        do_reset();
        rxf = 1'b0; rx_data = 8'h5A; out_ready = 1'b0;
        for (int t = 1; t <= 20 && t_rise < 0; t++) begin
            cycle();
            if (!rd && t_fall < 0) t_fall = t;
            if (rd && t_fall >= 0 && t_rise < 0) t_rise = t;
        end
        checks++;
        if (t_fall != SYNC_STAGES + 1) begin
            errors++;
            $display("FAIL read_latency: rd fell at cycle %0d, required %0d", t_fall, SYNC_STAGES + 1);
        end
        checks++;
        if (t_rise < 0 || t_rise - t_fall != RD_PULSE) begin
            errors++;
            $display("FAIL read_width: rd low %0d cycles, required %0d", t_rise - t_fall, RD_PULSE);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
            errors++;
            $display("FAIL read_data: valid=%b data=%h, required valid=1 data=5a", out_valid, out_data);
        end
        rx_data = 8'hA5;
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (!rd || !out_valid || out_data !== 8'h5A) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL read_stall: %0d bad cycles while out_ready=0, required 0", bad);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || rd !== 1'b1) begin
            errors++;
            $display("FAIL read_release: valid=%b rd=%b, required valid=0 rd=1", out_valid, rd);
        end
        cycle();
        checks++;
        if (rd !== 1'b0) begin
            errors++;
            $display("FAIL read_regrant: rd=%b one cycle after release, required 0", rd);
        end
        for (int i = 0; i < 6 && !rd; i++) cycle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            errors++;
            $display("FAIL read_second: valid=%b data=%h, required valid=1 data=a5", out_valid, out_data);
        end
    endtask

    task automatic test_single_write();
        int nrdy = 0, t_oe = -1, t_wrf = -1, t_wrr = -1, t_oef = -1, t_idle = -1, bad_tx = 0;
        do_reset();
        txe = 1'b0; in_valid = 1'b1; in_data = 8'hC3;
        for (int t = 1; t <= 20; t++) begin
            cycle();
            if (in_ready) nrdy++;
            if (data_oe && t_oe < 0) t_oe = t;
            if (!wr && t_wrf < 0) t_wrf = t;
            if (wr && t_wrf >= 0 && t_wrr < 0) t_wrr = t;
            if (!data_oe && t_oe >= 0 && t_oef < 0) t_oef = t;
            if (!busy && t_oe >= 0 && t_idle < 0) t_idle = t;
            if (t_oe >= 0 && (t_oef < 0 || t == t_oef) && tx_data !== 8'hC3) bad_tx++;
            if (data_oe) in_valid = 1'b0;
        end
        checks++;
        if (nrdy != 1) begin
            errors++;
            $display("FAIL write_ready: in_ready high %0d cycles, required 1", nrdy);
        end
        checks++;
        if (t_oe != SYNC_STAGES + 1 || t_wrf - t_oe != WR_SETUP) begin
            errors++;
            $display("FAIL write_setup: oe at %0d wr fall at %0d, required %0d and %0d",
                     t_oe, t_wrf, SYNC_STAGES + 1, SYNC_STAGES + 1 + WR_SETUP);
        end
        checks++;
        if (t_wrr - t_wrf != WR_PULSE || t_oef - t_wrr != 1) begin
            errors++;
            $display("FAIL write_strobe: wr low %0d oe hold %0d, required %0d and 1",
                     t_wrr - t_wrf, t_oef - t_wrr, WR_PULSE);
        end
        checks++;
        if (bad_tx != 0 || tx_data !== 8'hC3) begin
            errors++;
            $display("FAIL write_data: %0d unstable cycles final tx=%h, required 0 and c3", bad_tx, tx_data);
        end
        checks++;
        if (t_idle - t_oef != RECOVER + SYNC_STAGES) begin
            errors++;
            $display("FAIL write_recover: idle %0d cycles after oe fall, required %0d",
                     t_idle - t_oef, RECOVER + SYNC_STAGES);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0, t_rdy = -1, t_oe = -1;
        do_reset();
        txe = 1'b1; in_valid = 1'b1; in_data = 8'h3C;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (in_ready || !wr || data_oe) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold: %0d cycles with activity while txe=1, required 0", bad);
        end
        txe = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            cycle();
            if (in_ready && t_rdy < 0) t_rdy = t;
            if (data_oe && t_oe < 0) t_oe = t;
            if (data_oe) in_valid = 1'b0;
        end
        checks++;
        if (t_rdy != SYNC_STAGES || t_oe != SYNC_STAGES + 1) begin
            errors++;
            $display("FAIL backpressure_release: ready at %0d oe at %0d, required %0d and %0d",
                     t_rdy, t_oe, SYNC_STAGES, SYNC_STAGES + 1);
        end
    endtask

    task automatic test_simultaneous();
        int bad = 0, n = 0;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            host_rx.push_back(8'(i));
            prod.push_back(8'(i));
        end
        while (n < 300 && (host_rx.size() + prod.size() + exp_out.size() + exp_tx.size() != 0 || busy)) begin
            host_step(100, 0);
            n++;
        end
        for (int i = 0; i < 10; i++) host_step(100, 0);
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL simultaneous_timeout: transfers incomplete after %0d cycles", n);
        end
        for (int i = 0; i < ops.size(); i++) if (ops[i] != (i % 2)) bad++;
        checks++;
        if (ops.size() != 8 || bad != 0) begin
            errors++;
            $display("FAIL alternation: %0d accesses with %0d out of order, required 8 alternating R,W",
                     ops.size(), bad);
        end
    endtask

    task automatic test_flag_recovery();
        int nreads = 0;
        logic seen_low = 1'b0, found = 1'b0, prev = 1'b1;
        do_reset();
        rxf = 1'b0; rx_data = 8'h77; out_ready = 1'b1;
        for (int t = 0; t < 20 && !found; t++) begin
            cycle();
            if (!rd) seen_low = 1'b1;
            else if (seen_low) found = 1'b1;
        end
        checks++;
        if (!found || out_data !== 8'h77) begin
            errors++;
            $display("FAIL recovery_first: found=%b data=%h, required 1 and 77", found, out_data);
        end
        cycle();
        rxf = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (!rd && prev) nreads++;
            prev = rd;
        end
        checks++;
        if (nreads != 0) begin
            errors++;
            $display("FAIL recovery_extra: %0d extra reads after rxf rose, required 0", nreads);
        end
    endtask

    task automatic test_reset_mid_write();
        int bad = 0;
        logic found = 1'b0;
        do_reset();
        txe = 1'b0; in_valid = 1'b1; in_data = 8'h96;
        for (int t = 0; t < 20 && !found; t++) begin
            cycle();
            if (data_oe) in_valid = 1'b0;
            if (!wr) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midreset_start: wr never fell, required a write strobe");
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (wr !== 1'b1 || rd !== 1'b1 || data_oe !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_release: wr=%b rd=%b oe=%b busy=%b, required 1 1 0 0", wr, rd, data_oe, busy);
        end
        txe = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (!wr || data_oe || out_valid || busy) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midreset_after: %0d active cycles after reset, required 0", bad);
        end
    endtask

    task automatic test_random();
        int n = 0;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            host_rx.push_back(8'($urandom_range(255)));
            prod.push_back(8'($urandom_range(255)));
        end
        while (n < 4000 && (host_rx.size() + prod.size() + exp_out.size() + exp_tx.size() != 0 || busy)) begin
            host_step(60, 30);
            n++;
        end
        checks++;
        if (n >= 4000 || ops.size() != 48) begin
            errors++;
            $display("FAIL random_complete: %0d cycles %0d accesses, required under 4000 and 48", n, ops.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_backpressure();
        test_simultaneous();
        test_flag_recovery();
        test_reset_mid_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usbfifo_ctrl.md
Name: usbfifo_ctrl

Overview:
Sequencer for the FT2232H asynchronous FIFO interface. It synchronizes rxf/txe, generates timed rd/wr strobes and drives the transmit data-bus enable. It arbitrates round-robin between host->FPGA reads and FPGA->host writes. Internal logic sees two valid/ready byte streams instead of raw FT2232H pins.

Parameters:
SYNC_STAGES, 2, synchronizer depth on rxf and txe (>=2)
RD_PULSE, 2, clock cycles rd is held low (>=1)
WR_SETUP, 1, cycles tx_data/data_oe valid before wr falls (>=1)
WR_PULSE, 2, cycles wr is held low (>=1)
RECOVER, 1, idle cycles after a strobe before the next access (>=1)

Ports:
clock  input  1  single system clock, all logic on posedge
reset_n  input  1  asynchronous, active-low reset
rxf  input  1  FT2232H, low = byte available to read (async)
txe  input  1  FT2232H, low = space available to write (async)
rd  output  1  FT2232H read strobe, active low
wr  output  1  FT2232H write strobe, active low
rx_data  input  8  FT2232H data bus, read direction
tx_data  output  8  FT2232H data bus, write direction
data_oe  output  1  high = FPGA drives the data bus
out_data  output  8  byte received from host
out_valid  output  1  out_data valid; held until out_ready
out_ready  input  1  consumer accepts out_data
in_data  input  8  byte to send to host
in_valid  input  1  producer has a byte
in_ready  output  1  controller accepts in_data this cycle
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync release): rd=1, wr=1, data_oe=0, tx_data=0, out_data=0, out_valid=0, in_ready=0, busy=0, state=IDLE. Synchronizer flops reset to 1 (inactive). Priority bit selects read first.
- Reset asserted mid-access: strobes release immediately. Any in-flight byte is discarded; no partial transfer is reported.
- rxf_s/txe_s are the outputs of a SYNC_STAGES flop chain. Only these synchronized flags are used.
- read_ok = IDLE & !rxf_s & !out_valid.
- write_ok = IDLE & !txe_s & in_valid.
- Arbitration in IDLE:
  - Only one eligible: that one wins.
  - Both eligible: the one not served last wins.
  - The priority bit updates on each grant.
- in_ready = write_ok & write granted (combinational from state/flags). A write starts only on an in_valid & in_ready cycle.
- States: IDLE, RD_STROBE, WR_SETUP, WR_STROBE, WR_HOLD, RECOVER.
- Read, granted at edge N:
  - rd=0 from edge N to edge N+RD_PULSE (RD_STROBE).
  - At edge N+RD_PULSE: rx_data captured into out_data, out_valid=1, rd=1, go to RECOVER.
- Write, accepted at edge N:
  - At edge N: tx_data<=in_data, data_oe=1, enter WR_SETUP for WR_SETUP cycles.
  - Then wr=0 for WR_PULSE cycles (WR_STROBE).
  - Then wr=1 and tx_data/data_oe held for one more cycle (WR_HOLD).
  - Then data_oe=0, go to RECOVER. tx_data keeps its last value.
- RECOVER lasts RECOVER+SYNC_STAGES cycles so rxf_s/txe_s reflect the flag updates after the strobe; then return to IDLE.
- Read and write never overlap. rd and wr are never low simultaneously. data_oe=0 whenever rd=0.
- out_valid clears on out_valid & out_ready. A new read may be granted in that same IDLE cycle only from the following cycle (read_ok uses the registered out_valid).
- rxf/txe deasserting after a grant does not abort the access.
- Cycle counters are sized $clog2(max param)+1. Counts are exact, with no off-by-one: strobe widths equal their parameters in clock cycles.
- Throughput with defaults: read = 2+3 = 5 cycles; write = 1+2+1+3 = 7 cycles.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> rd=1, wr=1, data_oe=0, out_valid=0, in_ready=0. Assert reset_n=0 during WR_STROBE -> wr rises asynchronously, no transfer.
- Single read: rxf low, rx_data=0x5A, out_ready=0 -> rd low exactly 2 cycles; out_data=0x5A, out_valid=1 on the rd rising edge; no further rd until out_ready pulses.
- Single write: txe low, in_valid=1, in_data=0xC3 -> in_ready one cycle; data_oe high 1 cycle before wr falls; wr low 2 cycles; tx_data=0xC3 stable from data_oe rise until one cycle after wr rises.
- Simultaneous: rxf, txe low, in_valid held, out_ready=1, bytes 0x01..0x04 queued each side -> strict alternation R,W,R,W...; rd/wr never both low; data_oe never high while rd low.
- Back-pressure: txe high with in_valid=1 -> in_ready stays 0 and wr stays 1. Drop txe -> write starts SYNC_STAGES+1 cycles later.
- Flag recovery: rxf rises 1 cycle after rd rises and stays high -> no second read issued after RECOVER.
